// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Walks a 5-layer inference (CONV1, CONV2, CONV3, FC1, FC2) through the
//   datapath. Each layer is issued with a one-cycle layer_start pulse carrying
//   the layer id, its quantization scale and the activation SRAM base
//   addresses. The sequencer then waits for layer_done before issuing the next
//   layer. All five scales are captured at compute_start, so scale inputs may
//   change freely during a run.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   compute_start             pulse, starts a run (ignored while busy)
//   scale_CONV1..scale_FC2    per-layer scales, sampled at compute_start
//   layer_done                pulse from datapath, current layer finished
//   layer_start               pulse, run layer described by outputs below
//   layer_id                  0=CONV1 .. 4=FC2
//   layer_scale               snapshot scale for layer_id
//   act_in_base/act_out_base  activation SRAM word base addresses
//   busy                      run in progress
//   compute_finish            level, run ended (completed or aborted)
//   error                     level, run aborted by layer timeout
//
// Configuration
//   LAYER_TIMEOUT_EN  when defined, a layer that does not report layer_done
//                     within TIMEOUT_CYCLES WAIT cycles aborts the run with
//                     error set. When undefined, no counter exists and error
//                     is tied low.
module layer_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        compute_start,
  input  logic [31:0] scale_CONV1,
  input  logic [31:0] scale_CONV2,
  input  logic [31:0] scale_CONV3,
  input  logic [31:0] scale_FC1,
  input  logic [31:0] scale_FC2,
  input  logic        layer_done,
  output logic        layer_start,
  output logic [2:0]  layer_id,
  output logic [31:0] layer_scale,
  output logic [15:0] act_in_base,
  output logic [15:0] act_out_base,
  output logic        busy,
  output logic        compute_finish,
  output logic        error
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  localparam logic [2:0] LAST_ID = 3'd4;

  // A timeout of fewer than 2 cycles cannot be represented by the counter.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("layer_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  state_e      state_q;
  logic [2:0]  layer_id_q;
  logic [31:0] layer_scale_q;
  logic [15:0] in_base_q, out_base_q;
  logic        layer_start_q, busy_q, finish_q;
  logic [4:0][31:0] scale_q;   // snapshot, index = layer id

  // Next-layer descriptor, only consumed when layer_id_q < LAST_ID.
  logic [2:0]  nxt_id_d;
  logic [31:0] nxt_scale_d;
  logic [15:0] nxt_in_d, nxt_out_d;

  always_comb begin
    nxt_id_d    = layer_id_q + 3'd1;
    nxt_scale_d = '0;
    nxt_in_d    = 16'd0;
    nxt_out_d   = 16'd256;
    case (nxt_id_d)
      3'd1: begin nxt_scale_d = scale_q[1]; nxt_in_d = 16'd256; nxt_out_d = 16'd592; end
      3'd2: begin nxt_scale_d = scale_q[2]; nxt_in_d = 16'd592; nxt_out_d = 16'd692; end
      3'd3: begin nxt_scale_d = scale_q[3]; nxt_in_d = 16'd692; nxt_out_d = 16'd722; end
      3'd4: begin nxt_scale_d = scale_q[4]; nxt_in_d = 16'd722; nxt_out_d = 16'd743; end
      default: ;
    endcase
  end

`ifdef LAYER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt_q;
  logic          error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      layer_id_q    <= 3'd0;
      layer_scale_q <= '0;
      in_base_q     <= 16'd0;
      out_base_q    <= 16'd256;
      layer_start_q <= 1'b0;
      busy_q        <= 1'b0;
      finish_q      <= 1'b0;
      scale_q       <= '0;
`ifdef LAYER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (compute_start) begin
            scale_q       <= {scale_FC2, scale_FC1, scale_CONV3, scale_CONV2, scale_CONV1};
            layer_id_q    <= 3'd0;
            layer_scale_q <= scale_CONV1;
            in_base_q     <= 16'd0;
            out_base_q    <= 16'd256;
            layer_start_q <= 1'b1;
            busy_q        <= 1'b1;
            finish_q      <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
            error_q       <= 1'b0;
`endif
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // layer_start was raised on entry; this drops it after one cycle.
          layer_start_q <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
          tmo_cnt_q     <= '0;
`endif
          state_q       <= S_WAIT;
        end
        S_WAIT: begin
          // layer_done takes priority over a timeout on the same edge.
          if (layer_done) begin
            if (layer_id_q == LAST_ID) begin
              finish_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              layer_id_q    <= nxt_id_d;
              layer_scale_q <= nxt_scale_d;
              in_base_q     <= nxt_in_d;
              out_base_q    <= nxt_out_d;
              layer_start_q <= 1'b1;
              state_q       <= S_ISSUE;
            end
          end
`ifdef LAYER_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            error_q  <= 1'b1;
            finish_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign layer_start    = layer_start_q;
  assign layer_id       = layer_id_q;
  assign layer_scale    = layer_scale_q;
  assign act_in_base    = in_base_q;
  assign act_out_base   = out_base_q;
  assign busy           = busy_q;
  assign compute_finish = finish_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer. Stimulus pushes the expected
// layer_start descriptors and point-in-time output snapshots into queues;
// the monitor on the falling edge pops and compares them.
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst, compute_start, layer_done;
  logic [31:0] s_c1, s_c2, s_c3, s_f1, s_f2;
  logic        layer_start, busy, compute_finish, error;
  logic [2:0]  layer_id;
  logic [31:0] layer_scale;
  logic [15:0] act_in_base, act_out_base;

  always #5 clk = ~clk;

  layer_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .compute_start(compute_start),
    .scale_CONV1(s_c1), .scale_CONV2(s_c2), .scale_CONV3(s_c3),
    .scale_FC1(s_f1), .scale_FC2(s_f2), .layer_done(layer_done),
    .layer_start(layer_start), .layer_id(layer_id), .layer_scale(layer_scale),
    .act_in_base(act_in_base), .act_out_base(act_out_base),
    .busy(busy), .compute_finish(compute_finish), .error(error)
  );

  typedef struct {
    logic [2:0]  id;
    logic [31:0] scale;
    logic [15:0] inb, outb;
  } lexp_t;

  // kind: 0 = output snapshot, 1 = wait bound expired, 2 = scoreboard drained
  typedef struct {
    string       name;
    int          kind;
    logic        start, bsy, fin, err;
    logic [2:0]  id;
    logic [31:0] scale;
    logic [15:0] inb, outb;
  } cexp_t;

  lexp_t sbq[$];
  cexp_t chq[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] in_map  [5] = '{16'd0,   16'd256, 16'd592, 16'd692, 16'd722};
  logic [15:0] out_map [5] = '{16'd256, 16'd592, 16'd692, 16'd722, 16'd743};
  logic [31:0] exp_sc  [5];

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    lexp_t e;
    cexp_t c;
    if (layer_start) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL layer_start_unexpected: got pulse id=%0d, required no pulse", layer_id);
      end else begin
        e = sbq.pop_front();
        if (layer_id !== e.id || layer_scale !== e.scale || act_in_base !== e.inb ||
            act_out_base !== e.outb || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL layer_start_desc: got id=%0d scale=%0d in=%0d out=%0d busy=%b, required id=%0d scale=%0d in=%0d out=%0d busy=1",
                   layer_id, layer_scale, act_in_base, act_out_base, busy, e.id, e.scale, e.inb, e.outb);
        end
      end
    end
    while (chq.size() > 0) begin
      c = chq.pop_front();
      n_tests++;
      if (c.kind == 1) begin
        n_fail++;
        $display("FAIL %s: got no layer_start within bound, required a pulse", c.name);
      end else if (c.kind == 2) begin
        if (sbq.size() != 0) begin
          n_fail++;
          $display("FAIL %s: got %0d pending layer_start, required 0", c.name, sbq.size());
        end
      end else if (layer_start !== c.start || busy !== c.bsy || compute_finish !== c.fin ||
                   error !== c.err || layer_id !== c.id || layer_scale !== c.scale ||
                   act_in_base !== c.inb || act_out_base !== c.outb) begin
        n_fail++;
        $display("FAIL %s: got st=%b busy=%b fin=%b err=%b id=%0d scale=%0d in=%0d out=%0d, required st=%b busy=%b fin=%b err=%b id=%0d scale=%0d in=%0d out=%0d",
                 c.name, layer_start, busy, compute_finish, error, layer_id, layer_scale,
                 act_in_base, act_out_base, c.start, c.bsy, c.fin, c.err, c.id, c.scale, c.inb, c.outb);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_chk(input string n, input int kind, input logic st, input logic bsy,
                          input logic fin, input logic err, input logic [2:0] id,
                          input logic [31:0] sc, input logic [15:0] ib, input logic [15:0] ob);
    cexp_t c;
    c.name = n; c.kind = kind; c.start = st; c.bsy = bsy; c.fin = fin; c.err = err;
    c.id = id; c.scale = sc; c.inb = ib; c.outb = ob;
    chq.push_back(c);
  endtask

  task automatic push_reset_chk(input string n);
    push_chk(n, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 16'd0, 16'd256);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (layer_start) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic start_run(input string n, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [31:0] f);
    lexp_t e;
    s_c1 = a; s_c2 = b; s_c3 = c; s_f1 = d; s_f2 = f;
    exp_sc[0] = a; exp_sc[1] = b; exp_sc[2] = c; exp_sc[3] = d; exp_sc[4] = f;
    for (int l = 0; l < 5; l++) begin
      e.id = 3'(l); e.scale = exp_sc[l]; e.inb = in_map[l]; e.outb = out_map[l];
      sbq.push_back(e);
    end
    compute_start = 1'b1;
    tick();
    compute_start = 1'b0;
    push_chk(n, 0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, a, 16'd0, 16'd256);
  endtask

  // Datapath model: layer_done 10 cycles after each layer_start, with
  // optional disturbances at selected layers (-1 disables each).
  task automatic do_layers(input int zero_at, input int stray_at, input int abort_at,
                           input int silent_at);
    bit ok;
    for (int l = 0; l < 5; l++) begin
      wait_start(ok);
      if (!ok) begin
        push_chk("layer_start_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        sbq.delete();
        return;
      end
      if (l == zero_at) begin
        s_c1 = 0; s_c2 = 0; s_c3 = 0; s_f1 = 0; s_f2 = 0;
      end
      if (l == abort_at) begin
        tick(); tick(); tick();
        rst = 1'b1; compute_start = 1'b1;
        tick();
        push_reset_chk("reset_mid_run");
        rst = 1'b0; compute_start = 1'b0;
        sbq.delete();
        tick();
        push_reset_chk("reset_dominates_start");
        return;
      end
      if (l == silent_at) begin
        for (int k = 0; k < 16; k++) tick();
        push_chk("pre_timeout", 0, 1'b0, 1'b1, 1'b0, 1'b0, 3'(l), exp_sc[l], in_map[l], out_map[l]);
        tick();
        push_chk("timeout_abort", 0, 1'b0, 1'b0, 1'b1, 1'b1, 3'(l), exp_sc[l], in_map[l], out_map[l]);
        sbq.delete();
        return;
      end
      for (int k = 0; k < 10; k++) begin
        compute_start = (l == stray_at && k == 4);
        tick();
      end
      compute_start = 1'b0;
      layer_done = 1'b1;
      tick();
      layer_done = 1'b0;
    end
    push_chk("finish", 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, exp_sc[4], 16'd722, 16'd743);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; compute_start = 1'b0; layer_done = 1'b0;
    s_c1 = 0; s_c2 = 0; s_c3 = 0; s_f1 = 0; s_f2 = 0;
    tick(); tick();
    push_reset_chk("reset_state");
    rst = 1'b0;
    tick();
    push_reset_chk("idle_after_reset");

    // Full run; scales zeroed at layer 2 must not leak into layers 2..4.
    start_run("run1_start", 32'd96, 32'd11, 32'd22, 32'd33, 32'd217);
    do_layers(2, -1, -1, -1);

    // Back-to-back start one cycle after finish, stray start during layer 2.
    start_run("b2b_start", 32'd5, 32'd6, 32'd7, 32'd8, 32'd9);
    do_layers(-1, 2, -1, -1);

    // layer_done while idle must not issue anything.
    layer_done = 1'b1; tick(); layer_done = 1'b0; tick();
    push_chk("idle_done_ignored", 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 32'd9, 16'd722, 16'd743);

    // Reset in WAIT of layer 3, then restart from layer 0.
    start_run("run3_start", 32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000);
    do_layers(-1, -1, 3, -1);
    start_run("restart_start", 32'h1234_5678, 32'd42, 32'hFFFF_FFFF, 32'd0, 32'd77);
    do_layers(-1, -1, -1, -1);

`ifdef LAYER_TIMEOUT_EN
    start_run("tmo_run_start", 32'd3, 32'd4, 32'd5, 32'd6, 32'd7);
    do_layers(-1, -1, -1, 1);
    start_run("tmo_clear_start", 32'd8, 32'd9, 32'd10, 32'd11, 32'd12);
    do_layers(-1, -1, -1, -1);
`endif

    tick();
    push_chk("scoreboard_drained", 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: got no completion, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
